// File: rtl/sample_streamer.sv
// sample_streamer
//   Takes NUM_CH ADC channel samples per strobe and keeps one strobe in every (i_decim+1).
//   Each kept sample vector is buffered in a FIFO, then sent as a framed 8N1 UART packet:
//   SYNC_BYTE, then each channel zero-extended to 16 bits (low byte first, ch0 first).
//
//   Optional feature macro: SAMPLE_STREAMER_CHECKSUM_EN
//     When defined, one more byte is appended to each frame: the XOR of all data bytes.
//     SYNC_BYTE is not included in the XOR.
//
//   Ports
//     i_clk         core clock (single domain)
//     i_rst_n       asynchronous active-low reset
//     i_sample_stb  one-cycle pulse qualifying i_samples
//     i_samples     NUM_CH*SAMPLE_W bits; ch(k) at [k*SAMPLE_W +: SAMPLE_W]
//     i_decim       keep 1 of every (i_decim+1) strobes
//     o_uart_tx     serial line, idle high
//     o_busy        frame on the line or FIFO non-empty (registered)
//     o_overflow    sticky, set when a vector is dropped on a full FIFO
//     o_drop_count  number of dropped vectors, saturating at 16'hFFFF
module sample_streamer #(
  parameter int unsigned BAUD_CYCLES = 6,
  parameter int unsigned SAMPLE_W    = 12,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_sample_stb,
  input  logic [NUM_CH*SAMPLE_W-1:0] i_samples,
  input  logic [7:0]                 i_decim,
  output logic                       o_uart_tx,
  output logic                       o_busy,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_count
);

  localparam int unsigned VEC_W  = NUM_CH * SAMPLE_W;
  localparam int unsigned FRM_W  = NUM_CH * 16;
  localparam int unsigned NBYTES = 2 * NUM_CH;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned BCW    = $clog2(BAUD_CYCLES);
  localparam int unsigned BYW    = $clog2(NBYTES);

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_CYCLES - 1);
  localparam logic [BYW-1:0] BYTE_LAST = BYW'(NBYTES - 1);
  localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
`ifdef SAMPLE_STREAMER_CHECKSUM_EN
    , ST_CSUM = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [BYW-1:0]   byte_q, byte_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [7:0]       dec_q, dec_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_q, drop_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [VEC_W-1:0] mem_q [FIFO_DEPTH];

  logic             accept;
  logic             push;
  logic             pop;
  logic             frame_done;
  logic [7:0]       cur_byte;
  logic [FRM_W-1:0] head_frame;

  // FIFO head unpacked into the on-the-wire layout: each channel zero-extended to 16 bits.
  always_comb begin
    head_frame = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      head_frame[c*16 +: 16] = 16'(mem_q[rd_ptr_q][c*SAMPLE_W +: SAMPLE_W]);
    end
  end

`ifdef SAMPLE_STREAMER_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = 8'h00;
    for (int b = 0; b < int'(NBYTES); b++) begin
      csum = csum ^ frame_q[b*8 +: 8];
    end
  end
`endif

  // Byte currently being serialised, selected by which part of the frame we are in.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (state_q)
      ST_DATA: cur_byte = frame_q[int'(byte_q)*8 +: 8];
`ifdef SAMPLE_STREAMER_CHECKSUM_EN
      ST_CSUM: cur_byte = csum;
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // Frame sequencer. bit_q walks start(0), data(1..8), stop(9). tx_q is loaded one bit ahead,
  // so the value changes exactly at the bit boundary. A new frame is popped either from IDLE or
  // at the end of the last stop bit, so frames go out back to back with no idle gap.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    frame_d    = frame_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: tx_d = 1'b1;
      default: begin
        if (baud_q != BAUD_LAST) begin
          baud_d = baud_q + 1'b1;
        end else begin
          baud_d = '0;
          if (bit_q != 4'd9) begin
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
          end else begin
            bit_d = 4'd0;
            tx_d  = 1'b0;
            case (state_q)
              ST_SYNC: begin
                state_d = ST_DATA;
                byte_d  = '0;
              end
              ST_DATA: begin
                if (byte_q != BYTE_LAST) begin
                  byte_d = byte_q + 1'b1;
                end else begin
`ifdef SAMPLE_STREAMER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  frame_done = 1'b1;
`endif
                end
              end
              default: frame_done = 1'b1;
            endcase
          end
        end
      end
    endcase

    if ((state_q == ST_IDLE) || frame_done) begin
      if (count_q != '0) begin
        pop     = 1'b1;
        frame_d = head_frame;
        state_d = ST_SYNC;
        baud_d  = '0;
        bit_d   = 4'd0;
        byte_d  = '0;
        tx_d    = 1'b0;
      end else begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    end
  end

  // Decimation, FIFO bookkeeping and drop accounting. A push into a full FIFO is still accepted
  // when the sequencer pops in the same cycle, because the slot being read frees up.
  always_comb begin
    dec_d  = dec_q;
    accept = 1'b0;
    if (i_sample_stb) begin
      if (dec_q >= i_decim) begin
        accept = 1'b1;
        dec_d  = 8'd0;
      end else begin
        dec_d = dec_q + 8'd1;
      end
    end

    push     = accept && ((count_q != FIFO_FULL) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (accept && !push) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    busy_d = (state_d != ST_IDLE) || (count_d != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      byte_q   <= '0;
      frame_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      dec_q    <= 8'd0;
      ovf_q    <= 1'b0;
      drop_q   <= 16'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      frame_q  <= frame_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      dec_q    <= dec_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked entirely by count_q and the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_samples;
  end

  assign o_uart_tx    = tx_q;
  assign o_busy       = busy_q;
  assign o_overflow   = ovf_q;
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_sample_streamer.sv
module tb_sample_streamer;

  localparam int BAUD   = 6;
  localparam int SW     = 12;
  localparam int NCH    = 2;
  localparam int DEPTH  = 4;
`ifdef SAMPLE_STREAMER_CHECKSUM_EN
  localparam int FRAME_BYTES = 2 + 2*NCH;
`else
  localparam int FRAME_BYTES = 1 + 2*NCH;
`endif
  localparam int FRAME_CYC = 10 * BAUD * FRAME_BYTES;

  logic              clk;
  logic              rst_n;
  logic              sample_stb;
  logic [NCH*SW-1:0] samples;
  logic [7:0]        decim;
  logic              uart_tx;
  logic              busy;
  logic              overflow;
  logic [15:0]       drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  sample_streamer #(
    .BAUD_CYCLES(BAUD),
    .SAMPLE_W   (SW),
    .NUM_CH     (NCH),
    .FIFO_DEPTH (DEPTH),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sample_stb(sample_stb),
    .i_samples   (samples),
    .i_decim     (decim),
    .o_uart_tx   (uart_tx),
    .o_busy      (busy),
    .o_overflow  (overflow),
    .o_drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared comparison helper; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected line levels (one entry per clock) for the frame in flight,
  // plus the buffered sample vectors and the decimation/drop bookkeeping.
  bit              m_line[$];
  logic [NCH*SW-1:0] m_fifo[$];
  int              m_dec   = 0;
  bit              m_ovf   = 1'b0;
  int              m_drops = 0;

  // Expand one sample vector into the exact serial waveform of its frame.
  task automatic modelLoadFrame(input logic [NCH*SW-1:0] v);
    logic [7:0]  bytes[$];
    logic [15:0] ch;
    bytes.push_back(8'hA5);
    for (int c = 0; c < NCH; c++) begin
      ch = 16'(v[c*SW +: SW]);
      bytes.push_back(ch[7:0]);
      bytes.push_back(ch[15:8]);
    end
`ifdef SAMPLE_STREAMER_CHECKSUM_EN
    begin
      logic [7:0] cs;
      cs = 8'h00;
      for (int b = 1; b < bytes.size(); b++) cs = cs ^ bytes[b];
      bytes.push_back(cs);
    end
`endif
    foreach (bytes[b]) begin
      for (int k = 0; k < BAUD; k++) m_line.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < BAUD; k++) m_line.push_back(bytes[b][i]);
      for (int k = 0; k < BAUD; k++) m_line.push_back(1'b1);
    end
  endtask

  // Model advances once per clock: retire the level just sent, start the next frame when the
  // line is free, then handle the strobe (a vector fits if the FIFO has room after any pop).
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_line.delete();
        m_fifo.delete();
        m_dec   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
      end else begin
        if (m_line.size() != 0) void'(m_line.pop_front());
        if (m_line.size() == 0 && m_fifo.size() != 0) modelLoadFrame(m_fifo.pop_front());
        if (sample_stb) begin
          if (m_dec >= int'(decim)) begin
            m_dec = 0;
            if (m_fifo.size() < DEPTH) begin
              m_fifo.push_back(samples);
            end else begin
              m_ovf = 1'b1;
              if (m_drops < 65535) m_drops++;
            end
          end else begin
            m_dec++;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("tx",   16'(uart_tx),  16'((m_line.size() != 0) ? m_line[0] : 1'b1));
      checkOutput("busy", 16'(busy),     16'((m_line.size() != 0) || (m_fifo.size() != 0)));
      checkOutput("ovf",  16'(overflow), 16'(m_ovf));
      checkOutput("drops", drop_count,   16'(m_drops));
    end
  end

  // Line decoder: recovers bytes from the serial output by sampling each bit at mid-point.
  logic [7:0] rx_bytes[$];
  int         rx_cnt    = 0;
  bit         rx_active = 1'b0;
  logic [7:0] rx_shift  = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (uart_tx == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if ((rx_cnt % BAUD) == BAUD/2) begin
          if (rx_cnt / BAUD >= 1 && rx_cnt / BAUD <= 8) begin
            rx_shift[rx_cnt/BAUD - 1] = uart_tx;
          end else if (rx_cnt / BAUD == 9) begin
            rx_bytes.push_back(rx_shift);
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  // One strobe; entered and left on a negedge so back-to-back calls give consecutive strobes.
  task automatic applyStimulus(input logic [11:0] ch0, input logic [11:0] ch1, input logic [7:0] d);
    sample_stb = 1'b1;
    samples    = {ch1, ch0};
    decim      = d;
    @(negedge clk);
    sample_stb = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_t2[$];

  initial begin
    rst_n      = 1'b0;
    sample_stb = 1'b0;
    samples    = '0;
    decim      = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_tx",    16'(uart_tx),  16'h1);
    checkOutput("rst_busy",  16'(busy),     16'h0);
    checkOutput("rst_ovf",   16'(overflow), 16'h0);
    checkOutput("rst_drops", drop_count,    16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame: timing and byte content
    rx_bytes.delete();
    applyStimulus(12'h123, 12'hABC, 8'd0);
    checkOutput("t2_tx_after_push", 16'(uart_tx), 16'h1);
    checkOutput("t2_busy_after_push", 16'(busy), 16'h1);
    @(negedge clk);
    checkOutput("t2_start_bit", 16'(uart_tx), 16'h0);
    repeat (5) @(negedge clk);
    checkOutput("t2_start_last", 16'(uart_tx), 16'h0);
    @(negedge clk);
    checkOutput("t2_sync_bit0", 16'(uart_tx), 16'h1);
    repeat (FRAME_CYC - 7) @(negedge clk);
    checkOutput("t2_busy_end", 16'(busy), 16'h1);
    @(negedge clk);
    checkOutput("t2_busy_fall", 16'(busy), 16'h0);
    exp_t2 = '{8'hA5, 8'h23, 8'h01, 8'hBC, 8'h0A};
`ifdef SAMPLE_STREAMER_CHECKSUM_EN
    exp_t2.push_back(8'h94);
`endif
    checkOutput("t2_nbytes", 16'(rx_bytes.size()), 16'(exp_t2.size()));
    for (int i = 0; i < exp_t2.size(); i++) begin
      if (i < rx_bytes.size()) checkOutput($sformatf("t2_byte%0d", i), 16'(rx_bytes[i]), 16'(exp_t2[i]));
    end
    repeat (20) @(negedge clk);

    // Decimation by 4: strobes 4 and 8 are kept
    applyReset();
    rx_bytes.delete();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(12'h100 + 12'(k), 12'h200 + 12'(k), 8'd3);
      repeat (399) @(negedge clk);
    end
    checkOutput("t3_nbytes", 16'(rx_bytes.size()), 16'(2 * FRAME_BYTES));
    if (rx_bytes.size() == 2 * FRAME_BYTES) begin
      checkOutput("t3_f1_ch0lo", 16'(rx_bytes[1]), 16'h04);
      checkOutput("t3_f2_ch0lo", 16'(rx_bytes[FRAME_BYTES + 1]), 16'h08);
    end

    // Lowering i_decim below the running count keeps the next strobe
    applyReset();
    rx_bytes.delete();
    applyStimulus(12'h011, 12'h022, 8'd5);
    repeat (3) @(negedge clk);
    applyStimulus(12'h033, 12'h044, 8'd5);
    repeat (3) @(negedge clk);
    applyStimulus(12'h055, 12'h066, 8'd1);
    repeat (FRAME_CYC + 20) @(negedge clk);
    checkOutput("t_lowdec_nbytes", 16'(rx_bytes.size()), 16'(FRAME_BYTES));
    if (rx_bytes.size() > 3) checkOutput("t_lowdec_ch1lo", 16'(rx_bytes[3]), 16'h66);

    // Burst into a small FIFO: overflow, drops and back-to-back frames
    applyReset();
    rx_bytes.delete();
    for (int k = 0; k < 10; k++) applyStimulus(12'hF00 + 12'(k), 12'h0F0 + 12'(k), 8'd0);
    checkOutput("t4_drops", drop_count, 16'd5);
    checkOutput("t4_ovf", 16'(overflow), 16'h1);
    repeat (5 * FRAME_CYC - 9) @(negedge clk);
    checkOutput("t4_busy_end", 16'(busy), 16'h1);
    @(negedge clk);
    checkOutput("t4_busy_fall", 16'(busy), 16'h0);
    checkOutput("t4_nbytes", 16'(rx_bytes.size()), 16'(5 * FRAME_BYTES));

    // Reset asserted during the start bit of the first data byte
    rx_bytes.delete();
    applyStimulus(12'h123, 12'hABC, 8'd0);
    repeat (62) @(negedge clk);
    checkOutput("t6_pre_tx", 16'(uart_tx), 16'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_tx", 16'(uart_tx), 16'h1);
    checkOutput("t6_async_busy", 16'(busy), 16'h0);
    checkOutput("t6_async_drops", drop_count, 16'h0);
    checkOutput("t6_async_ovf", 16'(overflow), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("t6_idle_tx", 16'(uart_tx), 16'h1);
    checkOutput("t6_idle_busy", 16'(busy), 16'h0);
    checkOutput("t6_nbytes", 16'(rx_bytes.size()), 16'd1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
